uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Serial UART receiver with a receive FIFO. It is the producer side of the core's `uart_empty` / `uart_in` / `uart_rdreq` read port.
- Deserializes 8N1 frames from the `rxd` pin and pushes each good byte into a show-ahead FIFO.
- The CPU memory/IO unit pops bytes with `uart_rdreq` while `uart_empty` is low.
- Sits between the board RX pin and the core's memory-mapped UART read path.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated, must be >= 4.
- DEPTH_LOG2, 4, log2 of FIFO depth (depth 16).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rxd  in  1  asynchronous serial input, idle high.
- uart_rdreq  in  1  pop request from core; one byte per cycle while high.
- uart_empty  out  1  high when FIFO holds no bytes.
- uart_in  out  8  head-of-FIFO byte (show-ahead); 8'h00 while uart_empty.
- overrun  out  1  sticky; a good byte arrived while FIFO full and not popping.
- frame_err  out  1  sticky; stop bit sampled low.
- clear_err  in  1  synchronous clear of overrun and frame_err.

Behaviour:
Reset (async, rst_n low):
- uart_empty=1, uart_in=8'h00, overrun=0, frame_err=0.
- FSM=IDLE, pointers/count=0, synchronizer flops=1.
- FIFO storage is not reset.

Input conditioning:
- 2-flop synchronizer on rxd; FSM uses the synchronized bit only.

FSM:
- IDLE: on synced rxd==0, go START with bit counter cleared.
- START: wait to the mid-bit point (counter == CLKS_PER_BIT/2 - 1).
  - If rxd==1 there: false start, go IDLE.
  - Else clear counter and go DATA.
- DATA: every CLKS_PER_BIT clocks, sample one bit, LSB first, into the shift register. After the 8th bit, go STOP.
- STOP: after CLKS_PER_BIT clocks (mid stop bit), sample rxd.
  - rxd==1: issue a push of the shift register, go IDLE.
  - rxd==0: set frame_err, drop the byte, go BREAK.
- BREAK: wait until synced rxd==1, then go IDLE. Prevents a held-low line from re-triggering START.

FIFO (show-ahead, depth 2^DEPTH_LOG2):
- count is DEPTH_LOG2+1 bits; pointers wrap modulo depth.
- uart_empty = (count==0).
- uart_in = mem[rd_ptr] when count!=0, else 8'h00.
- Pop is effective only when uart_rdreq && count!=0. A read while empty is ignored: no pointer move, no error.
- Push is accepted when count<depth or a pop occurs in the same cycle.
  - If full with no pop, the byte is dropped and overrun is set.
- Simultaneous push and pop: both pointers advance, count unchanged.

Timing and flags:
- Latency: uart_empty falls on the clock edge after the stop-bit sample cycle.
- clear_err has priority below a same-cycle set; the set wins.

Reset mid-frame:
- Partial byte discarded, FSM returns to IDLE.
- If rxd is still low after release, it is treated as a new start bit. The glitch check in START discards a mid-frame low that does not span half a bit.

Decomposition:
- Shared package `uart_defs`:
  - FSM state encoding (IDLE, START, DATA, STOP, BREAK).
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
  - Function computing CLKS_PER_BIT from CLK_HZ and BAUD.
- One sub-module, `sync_fifo`: width 8, DEPTH_LOG2, push/pop/full/empty/count, show-ahead read. It is reusable for a future TX path.
- The bit-timing FSM stays in uart_rx_fifo.

Test Plan:
All scenarios use CLK_HZ=800, BAUD=100, so CLKS_PER_BIT=8.
1. Drive frame 0xA5 on rxd -> uart_empty falls one clk after the stop sample and uart_in=0xA5; pulse uart_rdreq 1 clk -> uart_empty=1, uart_in=0x00.
2. Drive rxd low for 2 clks, then high -> no byte, uart_empty stays 1, frame_err=0.
3. Drive 0x3C with stop bit 0, hold rxd low 20 bit-times, then send 0x11 -> frame_err=1 and 0x3C is never visible; next head byte is 0x11; clear_err -> frame_err=0.
4. Send 0x00..0x10 (17 bytes) with no reads -> overrun=1 after the 17th; popping yields 0x00..0x0F in order, then uart_empty=1.
5. FIFO full (16 bytes); assert uart_rdreq in the exact push cycle of a 17th byte 0x77 -> overrun=0; count stays 16; 0x77 is popped last.
6. Assert rst_n=0 during DATA bit 4 of 0x5A, release with rxd high, send 0xC3 -> uart_empty=1 through reset; only 0xC3 is received.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encoding, frame constants and bit-timing helper.
package uart_defs;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                     input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on o_rdata, zero while empty.
module sync_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_wdata,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_rdata,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_LOG2:0]   o_count
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  w_pop;
   logic                  w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == DEPTH_CNT);
   assign o_count = r_count;
   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

   // A push into a full FIFO still fits when the head leaves in the same cycle.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead receive FIFO, with sticky overrun/framing flags.
module uart_rx_fifo
   import uart_defs::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   input  logic       uart_rdreq,
   output logic       uart_empty,
   output logic [7:0] uart_in,
   output logic       overrun,
   output logic       frame_err,
   input  logic       clear_err
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W        = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   logic                  r_sync1;
   logic                  r_sync2;
   logic [2:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [BIT_W-1:0]      r_bit_idx;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_push;
   logic                  r_frame_err;
   logic                  r_overrun;
   logic                  w_rx;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_ovf_set;
   logic [DEPTH_LOG2:0]   w_count;

   assign w_rx      = r_sync2;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign uart_empty = (w_count == '0);
   assign w_ovf_set = r_push && w_full && !(uart_rdreq && !w_empty);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_push <= 1'b0;
         // Clear first so a same-cycle framing error below overrides it.
         if (clear_err) r_frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_rx) begin
                  r_state <= ST_START;
                  r_cnt   <= '0;
               end
            end
            ST_START: begin
               if (r_cnt == CNT_HALF) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= w_rx ? ST_IDLE : ST_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (r_cnt == CNT_FULL) begin
                  r_cnt     <= '0;
                  r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == LAST_BIT) r_state <= ST_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (r_cnt == CNT_FULL) begin
                  r_cnt <= '0;
                  if (w_rx) begin
                     r_push  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_BREAK: begin
               if (w_rx) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (w_ovf_set) begin
         r_overrun <= 1'b1;
      end else if (clear_err) begin
         r_overrun <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH      (DATA_BITS),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_push),
      .i_wdata (r_shift),
      .i_pop   (uart_rdreq),
      .o_rdata (uart_in),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule
